loop_mixer_n: RTL
=================

Name: loop_mixer_n

Overview:
- Parametrised N-channel loop mixer that replaces the fixed 8-bank mixer state machine in the looper top level.
- Stores the latest sample for each playing bank, then sums all banks and the live aux input, one channel per cycle.
- Applies a per-channel 4-bit gain and saturates the sum instead of letting it wrap.
- Produces an OUT_W-bit unsigned word for pwm_module, with a valid strobe and a clip indication.

Parameters:
- NUM_CH, 8, number of loop banks mixed (1..16)
- SAMPLE_W, 16, width of unsigned offset-binary samples from the RAM and XADC
- OUT_W, 11, width of the PWM output word (OUT_W <= SAMPLE_W)
- GAIN_W, 4, per-channel gain width; gain 2^(GAIN_W-1) is unity

Ports:
- clk_100MHz  in  1  system clock
- rst  in  1  asynchronous active-high reset
- playing  in  NUM_CH  bank-is-playing flags
- ch_valid  in  1  one-cycle strobe: ch_data is valid for bank ch_sel
- ch_sel  in  clog2(NUM_CH)  bank index for ch_data
- ch_data  in  SAMPLE_W  sample read from memory, offset binary
- aux_in  in  SAMPLE_W  live XADC sample, offset binary
- aux_en  in  1  include aux_in in the mix
- gain  in  NUM_CH*GAIN_W  per-channel gains; channel k uses bits [k*GAIN_W +: GAIN_W]
- mix_start  in  1  one-cycle strobe: compute a new output sample
- pwm_out  out  OUT_W  mixed sample for pwm_module
- mix_valid  out  1  one-cycle strobe when pwm_out updates
- busy  out  1  high while the mix is in progress
- clip  out  1  sticky flag: any mix has saturated since reset

Behaviour:
- Reset (async, immediate): all channel registers = 0, accumulator = 0, state = IDLE, pwm_out = 2^(OUT_W-1), mix_valid = 0, busy = 0, clip = 0.
- Sample conversion: signed value = data - 2^(SAMPLE_W-1).
- Channel capture, every cycle regardless of mixer state:
  - If ch_valid and playing[ch_sel], store signed(ch_data) into ch_reg[ch_sel].
  - If ch_valid and not playing[ch_sel], store 0.
  - Any channel whose playing bit is 0 is forced to 0 on the next cycle.
  - ch_sel >= NUM_CH is ignored.
- Accumulator width: ACC_W = SAMPLE_W + GAIN_W + clog2(NUM_CH+1) + 1, signed.
- Channel term: (ch_reg[k] * gain_k) >>> (GAIN_W-1), arithmetic shift.
- Aux term: signed(aux_in) at unity gain, or 0 if aux_en = 0.
- FSM:
  - IDLE: on mix_start, snapshot the aux term, acc = aux term, idx = 0, busy = 1, go to ACC. mix_start while busy is ignored (not queued).
  - ACC: acc += term(idx), idx++. After idx = NUM_CH-1, go to SAT. Takes NUM_CH cycles.
  - SAT: clamp acc to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. If clamped, set clip = 1. Add 2^(SAMPLE_W-1). Go to OUT.
  - OUT: pwm_out = result[SAMPLE_W-1 -: OUT_W], mix_valid = 1 for one cycle, busy = 0, go to IDLE.
- Latency: mix_start at cycle t gives mix_valid at cycle t+NUM_CH+2. A new mix_start is accepted in the cycle after mix_valid.
- Snapshot rules during ACC:
  - ch_valid writes land in ch_reg; the value used is whatever ch_reg holds when idx reaches that channel.
  - gain and playing are sampled per channel at that same cycle.
- pwm_out holds its value between mixes.
- Reset mid-mix aborts immediately and no mix_valid is produced.

Test Plan:
- Reset only, then mix_start with nothing playing, aux_en = 0 -> mix_valid at t+10 (NUM_CH = 8), pwm_out = 0x400, clip = 0.
- playing = 0x01, ch_valid sel 0 data 0xC000, gain0 = 8, aux_en = 1, aux_in = 0x8000 -> pwm_out = 0x600.
- playing = 0x0F, banks 0-3 data 0xFFFF, gains 15 -> pwm_out = 0x7FF, clip = 1. Clip stays 1 after a later quiet mix.
- playing = 0x01, bank 0 data 0x0000, gain 15 -> clamps at negative rail, pwm_out = 0x000, clip = 1.
- Bank 2 data 0xC000 gain 0, or playing[2] dropped after capture -> contribution 0, pwm_out = 0x400.
- mix_start reasserted during ACC -> ignored, exactly one mix_valid. rst pulsed mid-ACC -> busy = 0, pwm_out = 0x400 at once, no mix_valid.

Source files
------------

// File: rtl/loop_mixer_n.sv
// N-channel loop mixer: captures the latest sample per bank and accumulates all banks
// plus aux one channel per cycle, then saturates the gained sum into a PWM-width word.
module loop_mixer_n #(
  parameter int NUM_CH   = 8,
  parameter int SAMPLE_W = 16,
  parameter int OUT_W    = 11,
  parameter int GAIN_W   = 4,
  localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_100MHz,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        playing,
  input  logic                     ch_valid,
  input  logic [SEL_W-1:0]         ch_sel,
  input  logic [SAMPLE_W-1:0]      ch_data,
  input  logic [SAMPLE_W-1:0]      aux_in,
  input  logic                     aux_en,
  input  logic [NUM_CH*GAIN_W-1:0] gain,
  input  logic                     mix_start,
  output logic [OUT_W-1:0]         pwm_out,
  output logic                     mix_valid,
  output logic                     busy,
  output logic                     clip
);

  localparam int ACC_W  = SAMPLE_W + GAIN_W + $clog2(NUM_CH + 1) + 1;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_SAT  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic signed [ACC_W-1:0] POS_RAIL = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] NEG_RAIL = -POS_RAIL - 1;
  localparam logic [OUT_W-1:0]        PWM_MID  = OUT_W'(2 ** (OUT_W - 1));

  // Offset binary to two's complement: subtracting half scale just flips the MSB.
  function automatic logic signed [SAMPLE_W-1:0] to_signed(input logic [SAMPLE_W-1:0] v);
    return {~v[SAMPLE_W-1], v[SAMPLE_W-2:0]};
  endfunction

  logic signed [SAMPLE_W-1:0] ch_reg_q [NUM_CH];
  logic signed [SAMPLE_W-1:0] ch_reg_d [NUM_CH];
  logic [1:0]                 state_q, state_d;
  logic [SEL_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [OUT_W-1:0]           pwm_q, pwm_d;
  logic                       mix_valid_q, mix_valid_d;
  logic                       busy_q, busy_d;
  logic                       clip_q, clip_d;

  logic signed [SAMPLE_W-1:0] ch_cur;
  logic [GAIN_W-1:0]          gain_cur;
  logic                       play_cur;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    term;
  logic [SAMPLE_W-1:0]        sat;
  logic                       sat_hit;
  logic [SAMPLE_W-1:0]        result;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_reg_d[k] = ch_reg_q[k];
      if (!playing[k]) begin
        ch_reg_d[k] = '0;
      end else if (ch_valid && 32'(ch_sel) == k) begin
        ch_reg_d[k] = to_signed(ch_data);
      end
    end
  end

  // NOTE: every comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    ch_cur   = '0;
    gain_cur = '0;
    play_cur = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (32'(idx_q) == k) begin
        ch_cur   = ch_reg_q[k];
        gain_cur = gain[k*GAIN_W +: GAIN_W];
        play_cur = playing[k];
      end
    end
    prod = PROD_W'(ch_cur) * PROD_W'($signed({1'b0, gain_cur}));
    term = play_cur ? ACC_W'(prod >>> (GAIN_W - 1)) : '0;
  end

  always_comb begin
    sat_hit = 1'b0;
    sat     = acc_q[SAMPLE_W-1:0];
    if (acc_q > POS_RAIL) begin
      sat     = {1'b0, {(SAMPLE_W-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (acc_q < NEG_RAIL) begin
      sat     = {1'b1, {(SAMPLE_W-1){1'b0}}};
      sat_hit = 1'b1;
    end
    result = {~sat[SAMPLE_W-1], sat[SAMPLE_W-2:0]};
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    pwm_d       = pwm_q;
    mix_valid_d = 1'b0;
    busy_d      = busy_q;
    clip_d      = clip_q;
    case (state_q)
      S_IDLE: begin
        if (mix_start) begin
          acc_d   = aux_en ? ACC_W'(to_signed(aux_in)) : '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_q + term;
        idx_d = idx_q + 1'b1;
        if (32'(idx_q) == NUM_CH - 1) state_d = S_SAT;
      end
      S_SAT: begin
        clip_d      = clip_q | sat_hit;
        pwm_d       = result[SAMPLE_W-1 -: OUT_W];
        mix_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_OUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the per-bank registers are reset too, since a stale sample must never reach a mix.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) ch_reg_q[k] <= '0;
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      pwm_q       <= PWM_MID;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      for (int k = 0; k < NUM_CH; k++) ch_reg_q[k] <= ch_reg_d[k];
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      pwm_q       <= pwm_d;
      mix_valid_q <= mix_valid_d;
      busy_q      <= busy_d;
      clip_q      <= clip_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign mix_valid = mix_valid_q;
  assign busy      = busy_q;
  assign clip      = clip_q;

endmodule
